// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the 8-bit switch debouncer.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES edges; no backpressure (free-running sampler).
package switch_debounce_pkg;

  localparam int unsigned SW_WIDTH            = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_SYNC_STAGES     = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle between board pins, debouncer and peripheral; irq signals exist only with SWITCH_IRQ_EN.
// master = debouncer side, slave = consumer/driver side.
interface switch_debounce_if;
  import switch_debounce_pkg::*;

  logic [SW_WIDTH-1:0] sw_raw;
  logic [SW_WIDTH-1:0] switch;
  logic [SW_WIDTH-1:0] sw_changed;
`ifdef SWITCH_IRQ_EN
  logic                irq_en;
  logic                irq_clr;
  logic                irq;

  modport master (
    input  sw_raw,
    input  irq_en,
    input  irq_clr,
    output switch,
    output sw_changed,
    output irq
  );

  modport slave (
    output sw_raw,
    output irq_en,
    output irq_clr,
    input  switch,
    input  sw_changed,
    input  irq
  );
`else
  modport master (
    input  sw_raw,
    output switch,
    output sw_changed
  );

  modport slave (
    output sw_raw,
    input  switch,
    input  sw_changed
  );
`endif

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: SYNC_STAGES synchronizer, STABLE/COUNTING FSM and saturating-free counter.
// Accepts a level only after DEBOUNCE_CYCLES consecutive differing samples; no backpressure.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic switch,
  output logic changed
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  deb_state_t             state;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter reaching CNT_MAX means CNT_MAX consecutive differing samples have been seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= STABLE;
      cnt     <= '0;
      switch  <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      case (state)
        STABLE: begin
          if (sync != switch) begin
            state <= COUNTING;
            cnt   <= CW'(1);
          end
        end
        COUNTING: begin
          if (sync == switch) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= STABLE;
            cnt     <= '0;
            switch  <= sync;
            changed <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// 8-bit switch debouncer: eight independent debounce_bit lanes plus an optional level irq (SWITCH_IRQ_EN).
// Latency SYNC_STAGES + DEBOUNCE_CYCLES edges per bit; no backpressure.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  switch_debounce_if.master  bus
);

  logic [SW_WIDTH-1:0] switch_v;
  logic [SW_WIDTH-1:0] changed_v;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .raw     (bus.sw_raw[i]),
      .switch  (switch_v[i]),
      .changed (changed_v[i])
    );
  end

  assign bus.switch     = switch_v;
  assign bus.sw_changed = changed_v;

`ifdef SWITCH_IRQ_EN
  logic irq_q;

  // Set has priority over clear so an event landing with the clear strobe is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else if (bus.irq_en && (|changed_v)) begin
      irq_q <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge before any new drive.
module tb_switch_debounce;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses3;
  logic [7:0] chg_or;

  switch_debounce_if bus ();

  switch_debounce #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, accumulating every sw_changed value and bit-3 pulses seen.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chg_or = chg_or | bus.sw_changed;
      if (bus.sw_changed[3]) pulses3++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    pulses3 = 0;
    chg_or  = 8'h00;
    reset   = 1'b0;
    bus.sw_raw = 8'h00;
`ifdef SWITCH_IRQ_EN
    bus.irq_en  = 1'b0;
    bus.irq_clr = 1'b0;
`endif

    // Reset state
    step(2);
    chk("rst_switch", {24'd0, bus.switch}, 32'h00);
    chk("rst_changed", {24'd0, bus.sw_changed}, 32'h00);
`ifdef SWITCH_IRQ_EN
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);
`endif
    reset = 1'b1;
    step(3);

    // Clean step on bit 0: visible exactly 6 edges after the first sampling edge
    bus.sw_raw = 8'h01;
    step(6);
    chk("step_before", {24'd0, bus.switch}, 32'h00);
    step(1);
    chk("step_switch", {24'd0, bus.switch}, 32'h01);
    chk("step_changed", {24'd0, bus.sw_changed}, 32'h01);
    step(1);
    chk("step_changed_1cyc", {24'd0, bus.sw_changed}, 32'h00);
`ifdef SWITCH_IRQ_EN
    chk("step_irq_off", {31'd0, bus.irq}, 32'h0);
`endif

    // Bit 3 bounces with 2-cycle dwell, then holds high
    chg_or  = 8'h00;
    pulses3 = 0;
    for (int b = 0; b < 2; b++) begin
      bus.sw_raw = 8'h09;
      step(2);
      bus.sw_raw = 8'h01;
      step(2);
    end
    step(3);
    chk("bounce_switch", {24'd0, bus.switch}, 32'h01);
    chk("bounce_no_chg", {24'd0, chg_or}, 32'h00);
    bus.sw_raw = 8'h09;
    step(6);
    chk("hold_before", {24'd0, bus.switch}, 32'h01);
    step(1);
    chk("hold_switch", {24'd0, bus.switch}, 32'h09);
    chk("hold_changed", {24'd0, bus.sw_changed}, 32'h08);
    step(8);
    chk("hold_one_pulse", pulses3, 1);
    chk("hold_stays", {24'd0, bus.switch}, 32'h09);

    // 1-cycle glitch on bit 7
    chg_or = 8'h00;
    bus.sw_raw = 8'h89;
    step(1);
    bus.sw_raw = 8'h09;
    step(10);
    chk("glitch_switch", {24'd0, bus.switch}, 32'h09);
    chk("glitch_no_chg", {24'd0, chg_or}, 32'h00);

    // Bits 0 and 5 rise together (bit 0 already high, so only bit 5 moves), then both fall
`ifdef SWITCH_IRQ_EN
    bus.irq_en = 1'b1;
`endif
    bus.sw_raw = 8'h29;
    step(7);
    chk("multi_rise_chg", {24'd0, bus.sw_changed}, 32'h20);
    chk("multi_rise_sw", {24'd0, bus.switch}, 32'h29);
`ifdef SWITCH_IRQ_EN
    chk("irq_not_yet", {31'd0, bus.irq}, 32'h0);
`endif
    step(1);
`ifdef SWITCH_IRQ_EN
    chk("irq_set", {31'd0, bus.irq}, 32'h1);
`endif
    chk("multi_rise_chg_end", {24'd0, bus.sw_changed}, 32'h00);
    bus.sw_raw = 8'h08;
    step(7);
    chk("multi_fall_chg", {24'd0, bus.sw_changed}, 32'h21);
    chk("multi_fall_sw", {24'd0, bus.switch}, 32'h08);
`ifdef SWITCH_IRQ_EN
    bus.irq_clr = 1'b1;
    step(1);
    chk("irq_set_beats_clr", {31'd0, bus.irq}, 32'h1);
    bus.irq_clr = 1'b0;
    bus.irq_en  = 1'b0;
    step(2);
    chk("irq_en_low_holds", {31'd0, bus.irq}, 32'h1);
    bus.irq_clr = 1'b1;
    step(1);
    chk("irq_cleared", {31'd0, bus.irq}, 32'h0);
    bus.irq_clr = 1'b0;
`else
    step(1);
`endif
    chk("multi_fall_chg_end", {24'd0, bus.sw_changed}, 32'h00);

    // All bits high, reset mid-count discards the count
    step(2);
    bus.sw_raw = 8'hFF;
    step(4);
    chk("pre_rst_switch", {24'd0, bus.switch}, 32'h08);
    reset = 1'b0;
    #1;
    chk("mid_rst_switch", {24'd0, bus.switch}, 32'h00);
    chk("mid_rst_changed", {24'd0, bus.sw_changed}, 32'h00);
`ifdef SWITCH_IRQ_EN
    chk("mid_rst_irq", {31'd0, bus.irq}, 32'h0);
`endif
    step(2);
    chk("rst_held_switch", {24'd0, bus.switch}, 32'h00);
    reset = 1'b1;
    step(6);
    chk("post_rst_before", {24'd0, bus.switch}, 32'h00);
    step(1);
    chk("post_rst_switch", {24'd0, bus.switch}, 32'hFF);
    chk("post_rst_changed", {24'd0, bus.sw_changed}, 32'hFF);
    step(1);
    chk("post_rst_chg_end", {24'd0, bus.sw_changed}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
